// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared encodings for the pipeline hazard controller.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] WB_SEL_PC4  = 2'b00;
    localparam logic [1:0] WB_SEL_ALU  = 2'b01;
    localparam logic [1:0] WB_SEL_DRAM = 2'b10;
    localparam logic [1:0] WB_SEL_EXT  = 2'b11;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : EX operand bypass select for one source register.
// Revision    : 1.0  initial release
// ============================================================================
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_wR,
    input  logic              mem_rf_we,
    input  logic [1:0]        mem_rf_wsel,
    input  logic [REG_AW-1:0] wb_wR,
    input  logic              wb_rf_we,
    output logic [1:0]        fwd
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Load data is not yet available in MEM, so only non-DRAM results bypass from there.
    assign w_mem_hit = mem_rf_we && (mem_wR != '0) && (mem_wR == rs) && (mem_rf_wsel != WB_SEL_DRAM);
    assign w_wb_hit  = wb_rf_we && (wb_wR != '0) && (wb_wR == rs);

    always_comb begin
        fwd = FWD_RF;
        if (w_mem_hit) begin
            fwd = FWD_MEM;
        end else if (w_wb_hit) begin
            fwd = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush/forward controller with DRAM-wait freeze FSM.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ID_rR1,
    input  logic [REG_AW-1:0] ID_rR2,
    input  logic              ID_re1,
    input  logic              ID_re2,
    input  logic [REG_AW-1:0] EX_rR1,
    input  logic [REG_AW-1:0] EX_rR2,
    input  logic [REG_AW-1:0] EX_wR,
    input  logic              EX_rf_we,
    input  logic [1:0]        EX_rf_wsel,
    input  logic [1:0]        EX_npc_op,
    input  logic [REG_AW-1:0] MEM_wR,
    input  logic              MEM_rf_we,
    input  logic [1:0]        MEM_rf_wsel,
    input  logic              MEM_dram_we,
    input  logic              dram_ack,
    input  logic [REG_AW-1:0] WB_wR,
    input  logic              WB_rf_we,
    output logic              pc_stall,
    output logic              IF_ID_stall,
    output logic              IF_ID_flush,
    output logic              ID_EX_stall,
    output logic              ID_EX_flush,
    output logic              EX_MEM_stall,
    output logic              MEM_WB_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              wait_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] c_wait_max = WCNT_W'(WAIT_MAX);

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_wait_cnt_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_mem_access;
    logic              w_mem_stall;
    logic              w_ctrl_hz;
    logic              w_load_use;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    assign w_mem_access = MEM_dram_we || (MEM_rf_we && (MEM_rf_wsel == WB_SEL_DRAM));
    assign w_ctrl_hz    = (EX_npc_op != NPC_PC4);
    assign w_load_use   = EX_rf_we && (EX_rf_wsel == WB_SEL_DRAM) && (EX_wR != '0) &&
                          ((ID_re1 && (ID_rR1 == EX_wR)) || (ID_re2 && (ID_rR2 == EX_wR)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HZ_RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
            if (pc_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // The freeze is asserted in the first miss cycle and dropped in the release
    // cycle (ack or timeout), letting the access retire on that edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;
        w_mem_stall    = 1'b0;
        case (r_state)
            HZ_RUN: begin
                if (w_mem_access && !dram_ack) begin
                    w_state_nxt    = HZ_MEM_WAIT;
                    w_wait_cnt_nxt = WCNT_W'(1);
                    w_mem_stall    = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                if (dram_ack) begin
                    w_state_nxt = HZ_RUN;
                end else if (r_wait_cnt == c_wait_max) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = HZ_RUN;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                    w_mem_stall    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HZ_RUN;
            end
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_flush = 1'b0;
        if (!rst) begin
            if (w_mem_stall) begin
                pc_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX_stall  = 1'b1;
                EX_MEM_stall = 1'b1;
                MEM_WB_flush = 1'b1;
            end else if (w_ctrl_hz) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (w_load_use) begin
                pc_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
            end
        end
    end

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (EX_rR1),
        .mem_wR      (MEM_wR),
        .mem_rf_we   (MEM_rf_we),
        .mem_rf_wsel (MEM_rf_wsel),
        .wb_wR       (WB_wR),
        .wb_rf_we    (WB_rf_we),
        .fwd         (w_fwd_a)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (EX_rR2),
        .mem_wR      (MEM_wR),
        .mem_rf_we   (MEM_rf_we),
        .mem_rf_wsel (MEM_rf_wsel),
        .wb_wR       (WB_wR),
        .wb_rf_we    (WB_rf_we),
        .fwd         (w_fwd_b)
    );

    assign fwd_a        = rst ? FWD_RF : w_fwd_a;
    assign fwd_b        = rst ? FWD_RF : w_fwd_b;
    assign wait_timeout = r_timeout;
    assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl (CNT_W=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int WAIT_MAX = 16;
    localparam int CNT_W    = 4;

    localparam logic [1:0] ALU  = 2'b01;
    localparam logic [1:0] DRAM = 2'b10;
    localparam logic [1:0] BR   = 2'b01;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] ID_rR1, ID_rR2, EX_rR1, EX_rR2, EX_wR, MEM_wR, WB_wR;
    logic              ID_re1, ID_re2, EX_rf_we, MEM_rf_we, MEM_dram_we, dram_ack, WB_rf_we;
    logic [1:0]        EX_rf_wsel, EX_npc_op, MEM_rf_wsel;
    logic              pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
    logic              EX_MEM_stall, MEM_WB_flush, wait_timeout;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [6:0]        strobes;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // {pc, IF_ID stall, IF_ID flush, ID_EX stall, ID_EX flush, EX_MEM stall, MEM_WB flush}
    assign strobes = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush};

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_rR1       (ID_rR1),
        .ID_rR2       (ID_rR2),
        .ID_re1       (ID_re1),
        .ID_re2       (ID_re2),
        .EX_rR1       (EX_rR1),
        .EX_rR2       (EX_rR2),
        .EX_wR        (EX_wR),
        .EX_rf_we     (EX_rf_we),
        .EX_rf_wsel   (EX_rf_wsel),
        .EX_npc_op    (EX_npc_op),
        .MEM_wR       (MEM_wR),
        .MEM_rf_we    (MEM_rf_we),
        .MEM_rf_wsel  (MEM_rf_wsel),
        .MEM_dram_we  (MEM_dram_we),
        .dram_ack     (dram_ack),
        .WB_wR        (WB_wR),
        .WB_rf_we     (WB_rf_we),
        .pc_stall     (pc_stall),
        .IF_ID_stall  (IF_ID_stall),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX_stall  (ID_EX_stall),
        .ID_EX_flush  (ID_EX_flush),
        .EX_MEM_stall (EX_MEM_stall),
        .MEM_WB_flush (MEM_WB_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .wait_timeout (wait_timeout),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ID_rR1 = '0; ID_rR2 = '0; EX_rR1 = '0; EX_rR2 = '0; EX_wR = '0; MEM_wR = '0; WB_wR = '0;
        ID_re1 = 1'b0; ID_re2 = 1'b0; EX_rf_we = 1'b0; MEM_rf_we = 1'b0; MEM_dram_we = 1'b0;
        dram_ack = 1'b0; WB_rf_we = 1'b0;
        EX_rf_wsel = 2'b00; EX_npc_op = 2'b00; MEM_rf_wsel = 2'b00;

        // Reset state, with a load-use pattern present that must be gated off
        EX_rf_we = 1'b1; EX_rf_wsel = DRAM; EX_wR = 5'd3; ID_re1 = 1'b1; ID_rR1 = 5'd3;
        EX_rR1 = 5'd3; WB_rf_we = 1'b1; WB_wR = 5'd3;
        step(); sample();
        check("rst_strobes", 32'(strobes), 32'h0);
        check("rst_fwd_a", 32'(fwd_a), 32'h0);
        check("rst_timeout", 32'(wait_timeout), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        step();
        rst = 1'b0; WB_rf_we = 1'b0; EX_rR1 = '0;

        // Load-use on rR1: one bubble
        sample();
        check("lu_strobes", 32'(strobes), 32'b1100100);
        step();
        EX_rf_we = 1'b0;
        sample();
        check("lu_after_strobes", 32'(strobes), 32'h0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Load-use plus taken branch: control hazard wins
        EX_rf_we = 1'b1; EX_npc_op = BR;
        sample();
        check("br_lu_strobes", 32'(strobes), 32'b0010100);
        step();
        EX_npc_op = 2'b00; ID_re1 = 1'b0; ID_re2 = 1'b1; ID_rR2 = 5'd3; ID_rR1 = 5'd9;
        // Load-use via rR2
        sample();
        check("lu2_strobes", 32'(strobes), 32'b1100100);
        step();
        EX_wR = 5'd0; ID_rR2 = 5'd0;
        sample();
        check("lu_r0_strobes", 32'(strobes), 32'h0);
        check("lu2_stall_cnt", 32'(stall_cnt), 32'd2);
        step();
        EX_rf_we = 1'b0; ID_re2 = 1'b0;

        // MEM load, ack after 3 stall cycles; a branch in EX is frozen meanwhile
        MEM_rf_we = 1'b1; MEM_rf_wsel = DRAM; MEM_wR = 5'd4; EX_npc_op = BR;
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("wait_strobes_%0d", i), 32'(strobes), 32'b1101011);
            step();
        end
        dram_ack = 1'b1;
        sample();
        check("ack_strobes", 32'(strobes), 32'b0010100);
        step();
        dram_ack = 1'b0; MEM_rf_we = 1'b0; MEM_rf_wsel = 2'b00; EX_npc_op = 2'b00;
        sample();
        check("ack_stall_cnt", 32'(stall_cnt), 32'd5);
        check("ack_no_timeout", 32'(wait_timeout), 32'h0);

        // Forwarding
        EX_rR1 = 5'd7; EX_rR2 = 5'd9;
        MEM_rf_we = 1'b1; MEM_rf_wsel = ALU; MEM_wR = 5'd7; WB_rf_we = 1'b1; WB_wR = 5'd7;
        #1;
        check("fwd_a_mem", 32'(fwd_a), 32'd1);
        check("fwd_b_none", 32'(fwd_b), 32'd0);
        MEM_rf_we = 1'b0;
        #1;
        check("fwd_a_wb", 32'(fwd_a), 32'd2);
        MEM_rf_we = 1'b1; MEM_rf_wsel = DRAM; dram_ack = 1'b1;
        #1;
        check("fwd_a_load_in_mem", 32'(fwd_a), 32'd2);
        check("single_cycle_access", 32'(strobes), 32'h0);
        MEM_rf_wsel = ALU; dram_ack = 1'b0;
        EX_rR1 = 5'd0; MEM_wR = 5'd0; WB_wR = 5'd0;
        #1;
        check("fwd_a_r0", 32'(fwd_a), 32'd0);
        EX_rR2 = 5'd5; MEM_wR = 5'd5; WB_wR = 5'd5;
        #1;
        check("fwd_b_mem", 32'(fwd_b), 32'd1);
        MEM_rf_we = 1'b0; WB_rf_we = 1'b0;
        step();

        // Timeout: store never acknowledged; counter saturates at 15
        MEM_dram_we = 1'b1;
        for (int i = 0; i < WAIT_MAX; i++) begin
            sample();
            check($sformatf("to_stall_%0d", i), 32'(pc_stall), 32'd1);
            step();
        end
        sample();
        check("to_release", 32'(strobes), 32'h0);
        step();
        MEM_dram_we = 1'b0;
        sample();
        check("to_flag", 32'(wait_timeout), 32'd1);
        check("to_sat_cnt", 32'(stall_cnt), 32'd15);
        EX_rf_we = 1'b1; EX_rf_wsel = DRAM; EX_wR = 5'd6; ID_re1 = 1'b1; ID_rR1 = 5'd6;
        step();
        EX_rf_we = 1'b0; ID_re1 = 1'b0;
        sample();
        check("sat_hold_cnt", 32'(stall_cnt), 32'd15);
        check("to_sticky", 32'(wait_timeout), 32'd1);

        // Reset in the middle of a wait clears everything immediately
        step();
        MEM_dram_we = 1'b1;
        step(); step();
        sample();
        check("mid_wait_stall", 32'(pc_stall), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_strobes", 32'(strobes), 32'h0);
        check("mid_rst_timeout", 32'(wait_timeout), 32'h0);
        check("mid_rst_cnt", 32'(stall_cnt), 32'h0);
        step();
        MEM_dram_we = 1'b1; dram_ack = 1'b1;
        rst = 1'b0;
        sample();
        check("post_rst_run", 32'(strobes), 32'h0);
        step();
        dram_ack = 1'b0;
        sample();
        check("post_rst_reenter", 32'(strobes), 32'b1101011);
        step();
        MEM_dram_we = 1'b0; dram_ack = 1'b1;
        step();
        dram_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
